// File: rtl/bcd_clock_hms.sv
// 24-hour BCD HH:MM:SS counter advanced by a synchronised 1 Hz tick, with front-panel set pulses.
// Define ALARM_EN to add the alarm compare (al_set/al_hh/al_mm in, alarm out).
module bcd_clock_hms #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAX_HOUR    = 23
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       clk_1hz,
  input  logic       run,
  input  logic       inc_min,
  input  logic       inc_hr,
  input  logic       clr_sec,
`ifdef ALARM_EN
  input  logic       al_set,
  input  logic [7:0] al_hh,
  input  logic [7:0] al_mm,
  output logic       alarm,
`endif
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       sec_pulse,
  output logic       day_wrap
);

  localparam logic [7:0] HourMax = 8'(((MAX_HOUR / 10) << 4) | (MAX_HOUR % 10));
  localparam logic [7:0] MinMax  = 8'h59;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    if (v == top) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  logic [SYNC_STAGES-1:0] sync_q, fill_q;
  logic                   prev_q, armed_q, armed_d;
  logic                   tick;
  logic [7:0]             hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
  logic                   sec_pulse_q, day_wrap_q, day_wrap_d;
  logic                   ss_carry, mm_carry;

  // Edges only count once a synchronised low has been seen after reset, so a clk_1hz that is
  // already high at release cannot masquerade as a rising edge.
  assign armed_d = armed_q | (fill_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES-1]);
  assign tick    = sync_q[SYNC_STAGES-1] & ~prev_q & armed_q & run;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q      <= '0;
      fill_q      <= '0;
      prev_q      <= 1'b0;
      armed_q     <= 1'b0;
      hh_q        <= 8'h00;
      mm_q        <= 8'h00;
      ss_q        <= 8'h00;
      sec_pulse_q <= 1'b0;
      day_wrap_q  <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], clk_1hz};
      fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      prev_q      <= sync_q[SYNC_STAGES-1];
      armed_q     <= armed_d;
      hh_q        <= hh_d;
      mm_q        <= mm_d;
      ss_q        <= ss_d;
      sec_pulse_q <= tick;
      day_wrap_q  <= day_wrap_d;
    end
  end

  // Set pulses win over carries on their own field and absorb the carry.
  always_comb begin
    ss_d       = ss_q;
    mm_d       = mm_q;
    hh_d       = hh_q;
    ss_carry   = 1'b0;
    mm_carry   = 1'b0;
    day_wrap_d = 1'b0;
    if (clr_sec) begin
      ss_d = 8'h00;
    end else if (tick) begin
      ss_carry = (ss_q == MinMax);
      ss_d     = bcd_inc(ss_q, MinMax);
    end
    if (inc_min) begin
      mm_d = bcd_inc(mm_q, MinMax);
    end else if (ss_carry) begin
      mm_carry = (mm_q == MinMax);
      mm_d     = bcd_inc(mm_q, MinMax);
    end
    if (inc_hr) begin
      hh_d = bcd_inc(hh_q, HourMax);
    end else if (mm_carry) begin
      day_wrap_d = (hh_q == HourMax);
      hh_d       = bcd_inc(hh_q, HourMax);
    end
  end

  assign hh        = hh_q;
  assign mm        = mm_q;
  assign ss        = ss_q;
  assign sec_pulse = sec_pulse_q;
  assign day_wrap  = day_wrap_q;

`ifdef ALARM_EN
  logic [7:0] al_hh_q, al_hh_d, al_mm_q, al_mm_d;
  logic       al_armed_q, al_armed_d, alarm_q, alarm_d;
  logic [5:0] al_cnt_q, al_cnt_d;
  logic       al_hit;

  // Out-of-range alarm values can never equal the counter, so no explicit validity check.
  assign al_hit = al_armed_q & tick & (hh_d == al_hh_q) & (mm_d == al_mm_q) & (ss_d == 8'h00);

  always_comb begin
    al_hh_d    = al_hh_q;
    al_mm_d    = al_mm_q;
    al_armed_d = al_armed_q;
    alarm_d    = alarm_q;
    al_cnt_d   = al_cnt_q;
    if (al_set) begin
      al_hh_d    = al_hh;
      al_mm_d    = al_mm;
      al_armed_d = 1'b1;
      alarm_d    = 1'b0;
      al_cnt_d   = 6'd0;
    end else if (al_hit) begin
      alarm_d  = 1'b1;
      al_cnt_d = 6'd0;
    end else if (alarm_q && tick) begin
      if (al_cnt_q == 6'd59) begin
        alarm_d  = 1'b0;
        al_cnt_d = 6'd0;
      end else begin
        al_cnt_d = al_cnt_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      al_hh_q    <= 8'h00;
      al_mm_q    <= 8'h00;
      al_armed_q <= 1'b0;
      alarm_q    <= 1'b0;
      al_cnt_q   <= 6'd0;
    end else begin
      al_hh_q    <= al_hh_d;
      al_mm_q    <= al_mm_d;
      al_armed_q <= al_armed_d;
      alarm_q    <= alarm_d;
      al_cnt_q   <= al_cnt_d;
    end
  end

  assign alarm = alarm_q;
`endif

endmodule
